irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt front end feeding the CPU control path. Synchronises external interrupt lines, latches them as pending, and applies a per-source enable mask and a global enable. It presents one registered `irq` request plus a stable 16-bit handler `irq_vector`, then retires the request when the control path pulses `reset_irq` at the end of its interrupt-entry sequence.

## Interface
- `NUM_SOURCES`, 8: number of interrupt lines (1..16).
- `SYNC_STAGES`, 2: synchroniser flops per line (>=2).
- `VECTOR_BASE`, 16'hFF00: handler address of source 0.
- `VECTOR_STRIDE`, 16'h0010: address spacing between consecutive sources.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_lines`  in  NUM_SOURCES  raw asynchronous interrupt sources.
- `irq_enable`  in  1  global interrupt enable (status-register bit).
- `mask_write`  in  1  load `enable_mask` from `mask_data` on this edge.
- `mask_data`  in  NUM_SOURCES  new enable mask; 1 = source enabled.
- `reset_irq`  in  1  acknowledge from control path, one-cycle pulse.
- `irq`  out  1  registered request to control path.
- `irq_vector`  out  16  PC value used when control path selects `pc_from_irq`.
- `irq_pending`  out  NUM_SOURCES  pending flags (status readback).
- `enable_mask`  out  NUM_SOURCES  current mask.

## Operation
- Reset values: `irq`=0, `irq_vector`=VECTOR_BASE, `irq_pending`=0, `enable_mask`=0, synchronisers 0, FSM IDLE.
- Candidates = `irq_pending & enable_mask`; the lowest index has the highest priority.
- FSM:
  - IDLE: if `irq_enable` is high and candidates are non-zero, latch the winning index into `active_idx` and go to ASSERT. Otherwise stay in IDLE.
  - ASSERT: `irq`=1. On `reset_irq`, go to HOLDOFF; in edge mode also clear `irq_pending[active_idx]`.
  - HOLDOFF: `irq`=0 for exactly one cycle, then go to IDLE.
- `irq_vector` = VECTOR_BASE + active_idx*VECTOR_STRIDE, computed modulo 2^16. It is registered on the IDLE->ASSERT edge and held until the next ASSERT entry.
- Once in ASSERT, the request is committed. Dropping `irq_enable`, a `mask_write` clearing the active bit, or the active line deasserting does not cancel `irq` or change `irq_vector`.
- `reset_irq` is ignored in IDLE and HOLDOFF.
- `mask_write` takes effect on the same edge in any state. It never alters `irq_pending`.
- A masked source still latches pending; it dispatches later once it is unmasked.

## Timing
- Line rise to pending set: SYNC_STAGES+1 cycles in edge mode, SYNC_STAGES cycles in level mode.
- Pending (enabled) to `irq`=1: 1 cycle from IDLE.
- `reset_irq` sampled high -> `irq`=0 on the same edge. The control path's following `reset_state` therefore sees `irq`=0.
- Minimum gap between requests: `irq` low for at least 2 cycles (HOLDOFF plus IDLE decision). This lets at least one instruction run between back-to-back interrupts.
- Edge mode, simultaneous new edge on `active_idx` and ack in the same cycle: set wins, pending stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately (async). A partially completed control-path entry sequence is abandoned.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined: pending[i] is set on a synchronised rising edge and cleared only by acknowledge of source i.
- `IRQ_EDGE_DETECT_EN` undefined: level mode. pending[i] equals the synchronised line and ack does not clear it; the device must deassert its line inside its handler.

## Structure
- Shared package `irq_types_pkg` in `types/` holds:
  - FSM state enum (IDLE, ASSERT, HOLDOFF);
  - default VECTOR_BASE and VECTOR_STRIDE localparams;
  - the priority-encode function.
- Sub-module `irq_sync`: one line's SYNC_STAGES flop chain plus rising-edge detect, with async active-low reset. The controller instantiates it NUM_SOURCES times.

## Test plan
- Edge mode, mask=8'h04, irq_enable=1, pulse line 2 -> `irq`=1 after 4 cycles, `irq_vector`=16'hFF20. `reset_irq` pulse -> `irq`=0 next edge and pending[2]=0.
- Lines 5 and 1 rise together, mask=8'hFF -> vector 16'hFF10 first. After ack and HOLDOFF, `irq` reasserts with vector 16'hFF50.
- Line 3 pending, mask=0 -> `irq` stays 0 and pending[3]=1. Write mask=8'h08 -> `irq`=1 one cycle later with vector 16'hFF30.
- In ASSERT, drop irq_enable and write mask=0 -> `irq` stays 1 and the vector is unchanged until `reset_irq`.
- New edge on the active line coincides with ack -> pending stays 1 and `irq` reasserts after HOLDOFF. Separately, `reset_irq` pulsed in IDLE -> no state change.
- Level mode (macro undefined): line 0 held high through ack -> `irq` reasserts after 2 low cycles. Async reset mid-ASSERT -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/irq_types_pkg.sv
// Shared types for the interrupt front end: FSM states, default vector layout
// and the fixed-priority encoder (lowest index wins).
// Latency: n/a (types and a pure function). Backpressure: n/a.
package irq_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } irq_state_t;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'hFF00;
  localparam logic [15:0] DEF_VECTOR_STRIDE = 16'h0010;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on req != 0).
  function automatic logic [3:0] prio_encode(input logic [15:0] req);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: SYNC_STAGES-flop synchroniser plus optional rising-edge detect.
// Latency: SYNC_STAGES cycles from line to detect. Backpressure: none (free-running).
// Ports: clock, reset (async active-low), line (raw async input),
//   detect (synchronised level, or a one-cycle rise pulse when IRQ_EDGE_DETECT_EN is defined).
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic detect
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], line};
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= chain[SYNC_STAGES-1];
  end

  assign detect = chain[SYNC_STAGES-1] & ~prev;
`else
  assign detect = chain[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: sync + pending latch, mask/global enable, priority pick, one registered irq + vector.
// Latency: enabled pending -> irq in 1 cycle from IDLE; reset_irq -> irq low on the same edge, 2 low cycles min.
// Backpressure: request held until reset_irq; new pending sources wait in irq_pending meanwhile.
// Ports: clock, reset (async active-low), irq_lines, irq_enable, mask_write/mask_data, reset_irq (ack)
//   -> irq, irq_vector, irq_pending, enable_mask.
// Build option: IRQ_EDGE_DETECT_EN selects edge-latched pending (cleared by ack); default is level mode.
module irq_controller
  import irq_types_pkg::*;
#(
  parameter int          NUM_SOURCES   = 8,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_lines,
  input  logic                   irq_enable,
  input  logic                   mask_write,
  input  logic [NUM_SOURCES-1:0] mask_data,
  input  logic                   reset_irq,
  output logic                   irq,
  output logic [15:0]            irq_vector,
  output logic [NUM_SOURCES-1:0] irq_pending,
  output logic [NUM_SOURCES-1:0] enable_mask
);

  logic [NUM_SOURCES-1:0] detect;
  logic [15:0]            cand;
  logic [3:0]             win_idx;
  logic [15:0]            vec_next;
  irq_state_t             state;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock  (clock),
      .reset  (reset),
      .line   (irq_lines[g]),
      .detect (detect[g])
    );
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [3:0]             active_idx;
  logic                   ack;
  logic [NUM_SOURCES-1:0] clear;
  logic [NUM_SOURCES-1:0] pending_q;

  assign ack = (state == ASSERT) && reset_irq;

  always_comb begin
    clear = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      clear[i] = ack && (active_idx == 4'(i));
    end
  end

  // A rise arriving on the same edge as the ack re-arms the source: set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= (pending_q & ~clear) | detect;
  end

  assign irq_pending = pending_q;
`else
  // Level mode: pending mirrors the synchronised line; the handler must drop it.
  assign irq_pending = detect;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          enable_mask <= '0;
    else if (mask_write) enable_mask <= mask_data;
  end

  always_comb begin
    cand = '0;
    cand[NUM_SOURCES-1:0] = irq_pending & enable_mask;
  end

  assign win_idx  = prio_encode(cand);
  assign vec_next = VECTOR_BASE + ({12'd0, win_idx} * VECTOR_STRIDE);

  // Once in ASSERT the request is committed: enable, mask and line changes are ignored
  // until the ack, so the vector the control path loads never moves under it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_vector <= VECTOR_BASE;
`ifdef IRQ_EDGE_DETECT_EN
      active_idx <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (irq_enable && (cand != 16'd0)) begin
`ifdef IRQ_EDGE_DETECT_EN
            active_idx <= win_idx;
`endif
            irq_vector <= vec_next;
            irq        <= 1'b1;
            state      <= ASSERT;
          end
        end
        ASSERT: begin
          if (reset_irq) begin
            irq   <= 1'b0;
            state <= HOLDOFF;
          end
        end
        HOLDOFF: state <= IDLE;
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a vector scoreboard; works in level and edge builds.
// Latency: n/a. Backpressure: n/a.
module tb_irq_controller;

  localparam int N = 8;
`ifdef IRQ_EDGE_DETECT_EN
  localparam int PEND_LAT = 3;
  localparam bit EDGE     = 1'b1;
`else
  localparam int PEND_LAT = 2;
  localparam bit EDGE     = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] irq_lines;
  logic         irq_enable;
  logic         mask_write;
  logic [N-1:0] mask_data;
  logic         reset_irq;
  logic         irq;
  logic [15:0]  irq_vector;
  logic [N-1:0] irq_pending;
  logic [N-1:0] enable_mask;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  always #5 clock = ~clock;

  irq_controller dut (
    .clock       (clock),
    .reset       (reset),
    .irq_lines   (irq_lines),
    .irq_enable  (irq_enable),
    .mask_write  (mask_write),
    .mask_data   (mask_data),
    .reset_irq   (reset_irq),
    .irq         (irq),
    .irq_vector  (irq_vector),
    .irq_pending (irq_pending),
    .enable_mask (enable_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_write = 1'b1;
    mask_data  = m;
    tick();
    mask_write = 1'b0;
  endtask

  // Ack with the given line state applied at the same time; irq must drop on that edge.
  task automatic ack(input string tag, input logic [N-1:0] lines);
    irq_lines = lines;
    reset_irq = 1'b1;
    tick();
    reset_irq = 1'b0;
    check({tag, " ack drop"}, irq, 1'b0);
  endtask

  // Bounded wait for irq; compares latency and the scoreboard's next vector.
  task automatic wait_irq(input string tag, input int lat);
    int c;
    logic [15:0] e;
    c = 0;
    while (irq !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, " latency"}, c, lat);
    check({tag, " vector"}, irq_vector, e);
  endtask

  initial begin
    reset = 1'b0; irq_lines = '0; irq_enable = 1'b0;
    mask_write = 1'b0; mask_data = '0; reset_irq = 1'b0;
    #12;
    check("rst irq", irq, 1'b0);
    check("rst vector", irq_vector, 16'hFF00);
    check("rst pending", irq_pending, 8'h00);
    check("rst mask", enable_mask, 8'h00);
    reset = 1'b1;
    tick();

    // Single source, mask 0x04
    irq_enable = 1'b1;
    write_mask(8'h04);
    check("mask load", enable_mask, 8'h04);
    exp_q.push_back(16'hFF20);
    irq_lines = 8'h04;
    wait_irq("line2", PEND_LAT + 1);
    check("line2 pending", irq_pending[2], 1'b1);
    ack("line2", 8'h00);
    check("line2 pend after ack", irq_pending[2], !EDGE);
    tick(3);
    check("line2 idle irq", irq, 1'b0);
    check("line2 idle pending", irq_pending, 8'h00);

    // Priority: lines 5 and 1 together
    write_mask(8'hFF);
    exp_q.push_back(16'hFF10);
    exp_q.push_back(16'hFF50);
    irq_lines = 8'h22;
    wait_irq("pri first", PEND_LAT + 1);
    ack("pri first", 8'h20);
    wait_irq("pri second", 2);
    ack("pri second", 8'h00);
    tick(4);
    check("pri idle irq", irq, 1'b0);
    check("pri idle pending", irq_pending, 8'h00);

    // Masked source latches pending, dispatches once unmasked
    write_mask(8'h00);
    irq_lines = 8'h08;
    tick(4);
    check("masked irq", irq, 1'b0);
    check("masked pending", irq_pending, 8'h08);
    exp_q.push_back(16'hFF30);
    write_mask(8'h08);
    wait_irq("unmask", 1);

    // Committed request survives enable drop, mask clear and line drop
    irq_enable = 1'b0;
    irq_lines  = 8'h00;
    write_mask(8'h00);
    tick(3);
    check("commit irq", irq, 1'b1);
    check("commit vector", irq_vector, 16'hFF30);
    check("commit mask", enable_mask, 8'h00);
    ack("commit", 8'h00);
    tick(3);
    check("commit after irq", irq, 1'b0);
    check("commit after pending", irq_pending, 8'h00);

    // Ack in IDLE is ignored
    irq_enable = 1'b1;
    reset_irq  = 1'b1;
    tick();
    reset_irq  = 1'b0;
    check("idle ack irq", irq, 1'b0);
    check("idle ack vector", irq_vector, 16'hFF30);
    tick();
    check("idle ack irq later", irq, 1'b0);

    write_mask(8'h01);
    exp_q.push_back(16'hFF00);
    irq_lines = 8'h01;
    wait_irq("line0", PEND_LAT + 1);
`ifdef IRQ_EDGE_DETECT_EN
    // New rise on the active line lands on the ack edge: set wins
    irq_lines = 8'h00;
    tick(3);
    irq_lines = 8'h01;
    tick(2);
    reset_irq = 1'b1;
    tick();
    reset_irq = 1'b0;
    check("coincide irq", irq, 1'b0);
    check("coincide pending", irq_pending[0], 1'b1);
    exp_q.push_back(16'hFF00);
    wait_irq("coincide reassert", 2);
`else
    // Line held through the ack re-requests after the minimum gap
    ack("held", 8'h01);
    exp_q.push_back(16'hFF00);
    wait_irq("held reassert", 2);
`endif
    ack("line0 final", 8'h00);
    tick(3);
    check("line0 final irq", irq, 1'b0);
    check("line0 final pending", irq_pending, 8'h00);

    // Async reset in ASSERT, checked between clock edges
    write_mask(8'h10);
    exp_q.push_back(16'hFF40);
    irq_lines = 8'h10;
    wait_irq("line4", PEND_LAT + 1);
    #3;
    reset = 1'b0;
    #1;
    check("async irq", irq, 1'b0);
    check("async vector", irq_vector, 16'hFF00);
    check("async mask", enable_mask, 8'h00);
    check("async pending", irq_pending, 8'h00);
    irq_lines = 8'h00;
    #10;
    reset = 1'b1;
    tick(2);
    check("post reset irq", irq, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
